// File: rtl/gen_window_scan_ctrl_pkg.sv
// rtl/gen_window_scan_ctrl_pkg.sv - shared encodings, beat counts and FSM states for the window scan
package gen_window_scan_ctrl_pkg;

  localparam logic [1:0] WS_4  = 2'd0;
  localparam logic [1:0] WS_8  = 2'd1;
  localparam logic [1:0] WS_16 = 2'd2;

  localparam logic [4:0] BEATS_4  = 5'd1;
  localparam logic [4:0] BEATS_8  = 5'd4;
  localparam logic [4:0] BEATS_16 = 5'd16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SAD = 2'd2
  } state_t;

  // Window edge length in pixels; 0 for the illegal encoding.
  function automatic logic [4:0] win_dim(input logic [1:0] ws);
    case (ws)
      WS_4:    win_dim = 5'd4;
      WS_8:    win_dim = 5'd8;
      WS_16:   win_dim = 5'd16;
      default: win_dim = 5'd0;
    endcase
  endfunction

  // Address beats needed to cover one window.
  function automatic logic [4:0] win_beats(input logic [1:0] ws);
    case (ws)
      WS_4:    win_beats = BEATS_4;
      WS_8:    win_beats = BEATS_8;
      WS_16:   win_beats = BEATS_16;
      default: win_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/gen_window_scan_ctrl_if.sv
// rtl/gen_window_scan_ctrl_if.sv - beat address stream to the adder stage and SAD return path
interface gen_window_scan_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        check_wcol_out;
  logic [ADDR_W-1:0] row_base_1;
  logic [ADDR_W-1:0] row_base_2;
  logic [ADDR_W-1:0] row_base_3;
  logic [ADDR_W-1:0] row_base_4;
  logic              win_valid;
  logic              win_ready;
  logic              sad_valid;
  logic [31:0]       sad_in;

  modport master (
    output check_wcol_out, row_base_1, row_base_2, row_base_3, row_base_4, win_valid,
    input  win_ready, sad_valid, sad_in
  );

  modport slave (
    input  check_wcol_out, row_base_1, row_base_2, row_base_3, row_base_4, win_valid,
    output win_ready, sad_valid, sad_in
  );
endinterface

// File: rtl/gen_window_rowptr.sv
// rtl/gen_window_rowptr.sv - incremental row pointers producing the four row bases of a beat
module gen_window_rowptr
  import gen_window_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [DIM_W-1:0]  cols,
  input  logic [1:0]        win_size,
  input  logic              beat_adv,
  input  logic              col_adv,
  input  logic              row_adv,
  output logic [ADDR_W-1:0] row_base_1,
  output logic [ADDR_W-1:0] row_base_2,
  output logic [ADDR_W-1:0] row_base_3,
  output logic [ADDR_W-1:0] row_base_4
);

  // line_ptr: start of the origin row (wc=0); org_ptr: window origin; row_ptr: first row of beat
  logic [ADDR_W-1:0] line_ptr, org_ptr, row_ptr;
  logic [ADDR_W-1:0] cols_a, cols2, cols3, beat_stride, next_line, next_org;

  assign cols_a      = ADDR_W'(cols);
  assign cols2       = cols_a << 1;
  assign cols3       = cols2 + cols_a;
  assign beat_stride = (win_size == WS_8) ? cols2 : cols_a;
  assign next_line   = line_ptr + cols_a;
  assign next_org    = org_ptr + ADDR_W'(1);

  // Step the pointers: new frame, next origin row, next origin column, or next beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_ptr <= '0;
      org_ptr  <= '0;
      row_ptr  <= '0;
    end else if (load) begin
      line_ptr <= frame_base;
      org_ptr  <= frame_base;
      row_ptr  <= frame_base;
    end else if (row_adv) begin
      line_ptr <= next_line;
      org_ptr  <= next_line;
      row_ptr  <= next_line;
    end else if (col_adv) begin
      org_ptr <= next_org;
      row_ptr <= next_org;
    end else if (beat_adv) begin
      row_ptr <= row_ptr + beat_stride;
    end
  end

  // Spread the beat's rows over the four outputs according to the window size
  always_comb begin
    row_base_1 = row_ptr;
    row_base_2 = row_ptr;
    row_base_3 = row_ptr;
    row_base_4 = row_ptr;
    case (win_size)
      WS_4: begin
        row_base_2 = row_ptr + cols_a;
        row_base_3 = row_ptr + cols2;
        row_base_4 = row_ptr + cols3;
      end
      WS_8: begin
        row_base_3 = row_ptr + cols_a;
        row_base_4 = row_ptr + cols_a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gen_window_scan_ctrl.sv
// rtl/gen_window_scan_ctrl.sv - window scan sequencer with minimum-SAD tracking
module gen_window_scan_ctrl
  import gen_window_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      frame_base,
  input  logic [DIM_W-1:0]       frame_cols,
  input  logic [DIM_W-1:0]       frame_rows,
  input  logic [1:0]             win_size,
  gen_window_scan_ctrl_if.master win,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            best_sad,
  output logic [DIM_W-1:0]       best_row,
  output logic [DIM_W-1:0]       best_col
);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  cfg_cols, cfg_rows, cfg_w, in_w, wr, wc;
  logic [1:0]        cfg_ws;
  logic [3:0]        beat;
  logic              cfg_bad, last_beat, last_col, last_row;
  logic              accept, load, beat_adv, col_adv, row_adv, finish, sad_take;

  assign in_w      = DIM_W'(win_dim(win_size));
  assign cfg_bad   = (win_size == 2'd3) || (frame_cols < in_w) || (frame_rows < in_w);
  assign cfg_w     = DIM_W'(win_dim(cfg_ws));
  assign last_beat = ({1'b0, beat} == (win_beats(cfg_ws) - 5'd1));
  assign last_col  = (wc == cfg_cols - cfg_w);
  assign last_row  = (wr == cfg_rows - cfg_w);
  assign sad_take  = (state_q == WAIT_SAD) && win.sad_valid;

  assign busy               = (state_q != IDLE);
  assign win.win_valid      = (state_q == ISSUE);
  assign win.check_wcol_out = cfg_ws;

  gen_window_rowptr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_rowptr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .frame_base (frame_base),
    .cols       (cfg_cols),
    .win_size   (cfg_ws),
    .beat_adv   (beat_adv),
    .col_adv    (col_adv),
    .row_adv    (row_adv),
    .row_base_1 (win.row_base_1),
    .row_base_2 (win.row_base_2),
    .row_base_3 (win.row_base_3),
    .row_base_4 (win.row_base_4)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and one-cycle step controls
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    beat_adv = 1'b0;
    col_adv  = 1'b0;
    row_adv  = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!cfg_bad) begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (win.win_ready) begin
          if (last_beat) state_d = WAIT_SAD;
          else           beat_adv = 1'b1;
        end
      end
      WAIT_SAD: begin
        if (win.sad_valid) begin
          if (last_col && last_row) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
            if (last_col) row_adv = 1'b1;
            else          col_adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config capture, window position, beat index, best-SAD tracking and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_cols <= '0;
      cfg_rows <= '0;
      cfg_ws   <= '0;
      wr       <= '0;
      wc       <= '0;
      beat     <= '0;
      best_sad <= '1;
      best_row <= '0;
      best_col <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish | (accept & cfg_bad);
      if (accept) begin
        cfg_cols <= frame_cols;
        cfg_rows <= frame_rows;
        cfg_ws   <= win_size;
        wr       <= '0;
        wc       <= '0;
        beat     <= '0;
        best_sad <= '1;
        best_row <= '0;
        best_col <= '0;
        err      <= cfg_bad;
      end
      if (beat_adv) beat <= beat + 4'd1;
      if (col_adv || row_adv) beat <= '0;
      if (col_adv) wc <= wc + DIM_W'(1);
      if (row_adv) begin
        wc <= '0;
        wr <= wr + DIM_W'(1);
      end
      // Strict compare: on a tie the earlier window keeps the title
      if (sad_take && (win.sad_in < best_sad)) begin
        best_sad <= win.sad_in;
        best_row <= wr;
        best_col <= wc;
      end
      if (win.sad_valid && (state_q != WAIT_SAD)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gen_window_scan_ctrl.sv
// tb/tb_gen_window_scan_ctrl.sv - directed table-driven bench for gen_window_scan_ctrl
module tb_gen_window_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] frame_base;
  logic [7:0]  frame_cols;
  logic [7:0]  frame_rows;
  logic [1:0]  win_size;
  logic        busy, done, err;
  logic [31:0] best_sad;
  logic [7:0]  best_row, best_col;

  gen_window_scan_ctrl_if #(.ADDR_W(32)) win_if ();

  gen_window_scan_ctrl #(.ADDR_W(32), .DIM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_base (frame_base),
    .frame_cols (frame_cols),
    .frame_rows (frame_rows),
    .win_size   (win_size),
    .win        (win_if),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .best_sad   (best_sad),
    .best_row   (best_row),
    .best_col   (best_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [7:0]  cols;
    logic [7:0]  rows;
    logic [1:0]  ws;
    logic [31:0] sads [4];
    int          chk_win;
    int          chk_beat;
    logic [31:0] exp_rb [4];
    int          exp_wins;
    int          exp_bpw;
    logic [31:0] exp_sad;
    logic [7:0]  exp_row;
    logic [7:0]  exp_col;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic add(input logic [31:0] base, input logic [7:0] cols, input logic [7:0] rows,
                     input logic [1:0] ws, input logic [31:0] s0, input logic [31:0] s1,
                     input logic [31:0] s2, input logic [31:0] s3, input int cw, input int cb,
                     input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] r3, input int wins, input int bpw,
                     input logic [31:0] bsad, input logic [7:0] brow, input logic [7:0] bcol,
                     input logic eerr);
    vec_t v;
    v.base = base; v.cols = cols; v.rows = rows; v.ws = ws;
    v.sads[0] = s0; v.sads[1] = s1; v.sads[2] = s2; v.sads[3] = s3;
    v.chk_win = cw; v.chk_beat = cb;
    v.exp_rb[0] = r0; v.exp_rb[1] = r1; v.exp_rb[2] = r2; v.exp_rb[3] = r3;
    v.exp_wins = wins; v.exp_bpw = bpw;
    v.exp_sad = bsad; v.exp_row = brow; v.exp_col = bcol; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic check_bases(input string name, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] e3, input logic [31:0] e4);
    chk({name, "_rb1"}, win_if.row_base_1, e1);
    chk({name, "_rb2"}, win_if.row_base_2, e2);
    chk({name, "_rb3"}, win_if.row_base_3, e3);
    chk({name, "_rb4"}, win_if.row_base_4, e4);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          beat_i, wins, beats, sel_bad, cyc;
    logic        fin;
    logic [31:0] got_rb [4];
    for (int k = 0; k < 4; k++) got_rb[k] = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b1; frame_base = v.base; frame_cols = v.cols; frame_rows = v.rows; win_size = v.ws;
    win_if.win_ready = 1'b1; win_if.sad_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0; cyc = 0; beat_i = 0; wins = 0; beats = 0; sel_bad = 0;
    while (!fin && cyc < 1000) begin
      win_if.sad_valid = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else if (win_if.win_valid) begin
        if (win_if.check_wcol_out !== v.ws) sel_bad++;
        if (wins == v.chk_win && beat_i == v.chk_beat) begin
          got_rb[0] = win_if.row_base_1; got_rb[1] = win_if.row_base_2;
          got_rb[2] = win_if.row_base_3; got_rb[3] = win_if.row_base_4;
        end
        beat_i++; beats++;
      end else if (busy) begin
        win_if.sad_valid = 1'b1;
        win_if.sad_in = v.sads[wins[1:0]];
        wins++; beat_i = 0;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    win_if.sad_valid = 1'b0;
    chk({tag, "_done_seen"}, fin, 1'b1);
    if (!v.exp_err) begin
      for (int k = 0; k < 4; k++) chk($sformatf("%s_rb%0d", tag, k + 1), got_rb[k], v.exp_rb[k]);
      chk({tag, "_sel_bad"}, sel_bad, 0);
    end
    chk({tag, "_beats"}, beats, v.exp_wins * v.exp_bpw);
    chk({tag, "_wins"}, wins, v.exp_wins);
    chk({tag, "_best_sad"}, best_sad, v.exp_sad);
    chk({tag, "_best_row"}, best_row, v.exp_row);
    chk({tag, "_best_col"}, best_col, v.exp_col);
    chk({tag, "_err"}, err, v.exp_err);
    chk({tag, "_busy_end"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_base = '0; frame_cols = '0; frame_rows = '0; win_size = '0;
    win_if.win_ready = 1'b0; win_if.sad_valid = 1'b0; win_if.sad_in = '0;

    //   base          cols  rows  ws    sads                                  cw cb  row bases                                     wins bpw best_sad      row col err
    add(32'd100,       8'd4, 8'd4, 2'd0, 32'd77, 0, 0, 0,                       0, 0, 32'd100, 32'd104, 32'd108, 32'd112,        1, 1,  32'd77,       0, 0, 1'b0);
    add(32'd0,         8'd5, 8'd4, 2'd0, 32'd50, 32'd30, 0, 0,                  1, 0, 32'd1, 32'd6, 32'd11, 32'd16,              2, 1,  32'd30,       0, 1, 1'b0);
    add(32'd0,         8'd5, 8'd4, 2'd0, 32'd30, 32'd30, 0, 0,                  0, 0, 32'd0, 32'd5, 32'd10, 32'd15,              2, 1,  32'd30,       0, 0, 1'b0);
    add(32'd0,         8'd8, 8'd8, 2'd1, 32'd5, 0, 0, 0,                        0, 3, 32'd48, 32'd48, 32'd56, 32'd56,            1, 4,  32'd5,        0, 0, 1'b0);
    add(32'd1000,      8'd16, 8'd16, 2'd2, 32'd123, 0, 0, 0,                    0, 5, 32'd1080, 32'd1080, 32'd1080, 32'd1080,    1, 16, 32'd123,      0, 0, 1'b0);
    add(32'd200,       8'd5, 8'd5, 2'd0, 32'd90, 32'd80, 32'd20, 32'd60,        2, 0, 32'd205, 32'd210, 32'd215, 32'd220,        4, 1,  32'd20,       1, 0, 1'b0);
    add(32'hFFFF_FFFA, 8'd4, 8'd4, 2'd0, 32'hFFFF_FFFF, 0, 0, 0,                0, 0, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2, 32'd6, 1, 1, 32'hFFFF_FFFF, 0, 0, 1'b0);
    add(32'd0,         8'd16, 8'd16, 2'd3, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 0,                                0, 1,  32'hFFFF_FFFF, 0, 0, 1'b1);
    add(32'd0,         8'd3, 8'd4, 2'd0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0,                                0, 1,  32'hFFFF_FFFF, 0, 0, 1'b1);
    add(32'd0,         8'd8, 8'd7, 2'd1, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0,                                0, 4,  32'hFFFF_FFFF, 0, 0, 1'b1);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_win_valid", win_if.win_valid, 1'b0);
    chk("rst_sel", win_if.check_wcol_out, 2'd0);
    check_bases("rst", 0, 0, 0, 0);
    chk("rst_best_sad", best_sad, 32'hFFFF_FFFF);
    chk("rst_best_row", best_row, 8'd0);
    chk("rst_best_col", best_col, 8'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // 8x8 with backpressure, plus sad_valid and a stray start during ISSUE
    @(negedge clk);
    start = 1'b1; frame_base = 32'd0; frame_cols = 8'd8; frame_rows = 8'd8; win_size = 2'd1;
    win_if.win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("bp_first_valid", win_if.win_valid, 1'b1);
    chk("bp_busy", busy, 1'b1);
    check_bases("bp_b0", 32'd0, 32'd0, 32'd8, 32'd8);
    win_if.win_ready = 1'b1;
    @(negedge clk);
    check_bases("bp_b1", 32'd16, 32'd16, 32'd24, 32'd24);
    win_if.win_ready = 1'b0;
    @(negedge clk);
    check_bases("bp_hold1", 32'd16, 32'd16, 32'd24, 32'd24);
    win_if.sad_valid = 1'b1; win_if.sad_in = 32'd0;
    start = 1'b1; frame_base = 32'd500; win_size = 2'd0;
    @(negedge clk);
    win_if.sad_valid = 1'b0; start = 1'b0;
    chk("bp_err_issue", err, 1'b1);
    chk("bp_still_valid", win_if.win_valid, 1'b1);
    chk("bp_sel_kept", win_if.check_wcol_out, 2'd1);
    chk("bp_best_untouched", best_sad, 32'hFFFF_FFFF);
    check_bases("bp_hold2", 32'd16, 32'd16, 32'd24, 32'd24);
    @(negedge clk);
    check_bases("bp_hold3", 32'd16, 32'd16, 32'd24, 32'd24);
    win_if.win_ready = 1'b1;
    @(negedge clk);
    check_bases("bp_b2", 32'd32, 32'd32, 32'd40, 32'd40);
    @(negedge clk);
    check_bases("bp_b3", 32'd48, 32'd48, 32'd56, 32'd56);
    @(negedge clk);
    chk("bp_wait_valid", win_if.win_valid, 1'b0);
    chk("bp_wait_busy", busy, 1'b1);
    win_if.sad_valid = 1'b1; win_if.sad_in = 32'd9;
    @(negedge clk);
    win_if.sad_valid = 1'b0;
    chk("bp_done", done, 1'b1);
    chk("bp_busy_end", busy, 1'b0);
    chk("bp_best_sad", best_sad, 32'd9);
    chk("bp_err_sticky", err, 1'b1);

    // Reset during beat 2 of an 8x8 scan, then a clean rerun
    @(negedge clk);
    start = 1'b1; frame_base = 32'd0; frame_cols = 8'd8; frame_rows = 8'd8; win_size = 2'd1;
    win_if.win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_bases("mr_b2", 32'd32, 32'd32, 32'd40, 32'd40);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 1'b0);
    chk("mr_win_valid", win_if.win_valid, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_sel", win_if.check_wcol_out, 2'd0);
    check_bases("mr", 0, 0, 0, 0);
    chk("mr_best_sad", best_sad, 32'hFFFF_FFFF);
    rst = 1'b0;
    run_vec(vecs[3], "mr_rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
